// File: rtl/param_datapath_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the pipelined datapath.
// The multiplier is enabled by defining PARAM_DATAPATH_MUL_EN.
package param_datapath_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_PASS = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;

   typedef enum logic {S_RUN = 1'b0, S_MUL = 1'b1} state_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int NFLAGS = 3;

endpackage

// File: rtl/param_alu.sv
// Combinational single-cycle ALU; multiply is handled by the sequencer in the top.
module param_alu
   import param_datapath_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [3:0]        op,
   output logic [WIDTH-1:0]  result,
   output logic [NFLAGS-1:0] flags
);

   logic [WIDTH:0] wide;
   logic           carry;

   always_comb begin
      wide   = '0;
      carry  = 1'b0;
      result = a;
      case (op)
         OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         // the extra top bit of an unsigned subtract is the borrow
         OP_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[WIDTH-1:0];
            carry  = wide[WIDTH];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
         end
         default: result = a;
      endcase
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_N] = result[WIDTH-1];
   end

endmodule

// File: rtl/param_datapath.sv
// Pipelined register-file/ALU datapath: accept -> execute/writeback -> registered result.
// Define PARAM_DATAPATH_MUL_EN to add the iterative shift-add multiplier (op 9).
module param_datapath
   import param_datapath_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREGS = 16,
   localparam int AW    = $clog2(NREGS)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic             cmd_we,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [AW-1:0]    cmd_dst,
   input  logic [AW-1:0]    cmd_a,
   input  logic [AW-1:0]    cmd_b,
   input  logic [3:0]       cmd_op,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic [AW-1:0]    res_dst,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   input  logic [AW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   state_t            state;
   logic [WIDTH-1:0]  regFile [NREGS];
   logic [1:0]        vldPipe;          // [0]: execute stage occupied, [1]: result pulse
   logic              exLoad, exWe;
   logic [3:0]        exOp;
   logic [AW-1:0]     exDst;
   logic [WIDTH-1:0]  exData, exA, exB;
   logic [NFLAGS-1:0] resFlags;

   logic              accept, exFire, startMul, exWrite;
   logic [WIDTH-1:0]  rdA, rdB, aluRes, exRes;
   logic [NFLAGS-1:0] aluFlags, exFlags;

   assign cmd_ready = !reset && (state == S_RUN);
   assign accept    = cmd_valid && cmd_ready;
   assign exFire    = vldPipe[0] && (state == S_RUN);
`ifdef PARAM_DATAPATH_MUL_EN
   assign startMul  = exFire && !exLoad && (exOp == OP_MUL);
`else
   assign startMul  = 1'b0;
`endif
   assign exWrite   = exFire && !startMul && exWe;

   // bypass the write landing this cycle so back-to-back dependents see it
   assign rdA = (exWrite && exDst == cmd_a) ? exRes : regFile[cmd_a];
   assign rdB = (exWrite && exDst == cmd_b) ? exRes : regFile[cmd_b];

   param_alu #(.WIDTH(WIDTH)) uAlu (
      .a(exA), .b(exB), .op(exOp), .result(aluRes), .flags(aluFlags)
   );

   always_comb begin
      exRes   = exLoad ? exData : aluRes;
      exFlags = aluFlags;
      if (exLoad) begin
         exFlags         = '0;
         exFlags[FLAG_Z] = (exData == '0);
         exFlags[FLAG_N] = exData[WIDTH-1];
      end
   end

`ifdef PARAM_DATAPATH_MUL_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mulCand, mulAcc, mulSum;
   logic [WIDTH-1:0]   mulPlier;
   logic [CW-1:0]      mulCnt;
   logic [AW-1:0]      mulDst, exAAddr, exBAddr;
   logic               mulWe, mulDone;

   assign mulSum  = mulAcc + (mulPlier[0] ? mulCand : '0);
   assign mulDone = (state == S_MUL) && (mulCnt == MUL_LAST);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RUN;
         vldPipe  <= '0;
         res_data <= '0;
         res_dst  <= '0;
         resFlags <= '0;
         for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
      end else begin
         vldPipe[1] <= 1'b0;
         if (accept) begin
            vldPipe[0] <= 1'b1;
            exLoad     <= cmd_load;
            exWe       <= cmd_we;
            exOp       <= cmd_op;
            exDst      <= cmd_dst;
            exData     <= cmd_data;
            exA        <= rdA;
            exB        <= rdB;
`ifdef PARAM_DATAPATH_MUL_EN
            exAAddr    <= cmd_a;
            exBAddr    <= cmd_b;
`endif
         end else if (exFire) begin
            vldPipe[0] <= 1'b0;
         end

         if (exFire && !startMul) begin
            if (exWe) regFile[exDst] <= exRes;
            vldPipe[1] <= 1'b1;
            res_data   <= exRes;
            res_dst    <= exDst;
            resFlags   <= exFlags;
         end

`ifdef PARAM_DATAPATH_MUL_EN
         if (startMul) begin
            state    <= S_MUL;
            mulCand  <= {{WIDTH{1'b0}}, exA};
            mulPlier <= exB;
            mulAcc   <= '0;
            mulCnt   <= '0;
            mulDst   <= exDst;
            mulWe    <= exWe;
         end
         if (state == S_MUL) begin
            mulAcc   <= mulSum;
            mulCand  <= mulCand << 1;
            mulPlier <= mulPlier >> 1;
            mulCnt   <= mulCnt + 1'b1;
            if (mulDone) begin
               state            <= S_RUN;
               if (mulWe) regFile[mulDst] <= mulSum[WIDTH-1:0];
               vldPipe[1]       <= 1'b1;
               res_data         <= mulSum[WIDTH-1:0];
               res_dst          <= mulDst;
               resFlags[FLAG_Z] <= (mulSum[WIDTH-1:0] == '0);
               resFlags[FLAG_C] <= |mulSum[2*WIDTH-1:WIDTH];
               resFlags[FLAG_N] <= mulSum[WIDTH-1];
               // a command parked behind the multiply read stale operands
               if (mulWe && exAAddr == mulDst) exA <= mulSum[WIDTH-1:0];
               if (mulWe && exBAddr == mulDst) exB <= mulSum[WIDTH-1:0];
            end
         end
`endif
      end
   end

   assign res_valid = vldPipe[1];
   assign flag_z    = resFlags[FLAG_Z];
   assign flag_c    = resFlags[FLAG_C];
   assign flag_n    = resFlags[FLAG_N];
   assign dbg_data  = regFile[dbg_sel];

endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: directed plan plus random commands against an in-order model.
// MUL cases run only when PARAM_DATAPATH_MUL_EN is defined.
module tb_param_datapath;

   localparam int W  = 8;
   localparam int N  = 16;
   localparam int AW = 4;
   localparam int M  = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_load, cmd_we;
   logic [W-1:0]  cmd_data;
   logic [AW-1:0] cmd_dst, cmd_a, cmd_b;
   logic [3:0]    cmd_op;
   logic          res_valid;
   logic [W-1:0]  res_data;
   logic [AW-1:0] res_dst;
   logic          flag_z, flag_c, flag_n;
   logic [AW-1:0] dbg_sel;
   logic [W-1:0]  dbg_data;

   int nChecks = 0;
   int nFails  = 0;
   int mregs [N];

   typedef struct {int d; int dst; int f;} exp_t;
   exp_t expQ [$];

   always #5 clk = ~clk;

   param_datapath #(.WIDTH(W), .NREGS(N)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load), .cmd_we(cmd_we),
      .cmd_data(cmd_data), .cmd_dst(cmd_dst), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst),
      .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // sequential semantics: each accepted command sees every earlier command's write
   function automatic void model(input int ld, input int we, input int data, input int dst,
                                 input int a, input int b, input int op);
      int x, y, r, c, p, z, n;
      x = mregs[a];
      y = mregs[b];
      c = 0;
      if (ld != 0) r = data;
      else begin
         case (op)
            0: begin p = x + y; r = p & M; c = (p > M) ? 1 : 0; end
            1: begin r = (x - y) & M; c = (x < y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (~x) & M;
            6: begin r = (x * 2) & M; c = (x >> (W - 1)) & 1; end
            7: begin r = x / 2; c = x % 2; end
            9: begin
`ifdef PARAM_DATAPATH_MUL_EN
               p = x * y; r = p & M; c = (p > M) ? 1 : 0;
`else
               r = x;
`endif
            end
            default: r = x;
         endcase
      end
      z = (r == 0) ? 1 : 0;
      n = (r >> (W - 1)) & 1;
      expQ.push_back('{r, dst, z * 4 + c * 2 + n});
      if (we != 0) mregs[dst] = r;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (res_valid) begin
            if (expQ.size() == 0) chk("spurious_res_valid", {31'd0, res_valid}, 32'd0);
            else begin
               exp_t e;
               e = expQ.pop_front();
               chk("res_data", {24'd0, res_data}, e.d);
               chk("res_dst", {28'd0, res_dst}, e.dst);
               chk("res_flags_zcn", {29'd0, flag_z, flag_c, flag_n}, e.f);
            end
         end
         if (cmd_valid && cmd_ready)
            model(cmd_load, cmd_we, cmd_data, cmd_dst, cmd_a, cmd_b, cmd_op);
      end
   end

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int ld, input int we, input int data, input int dst,
                       input int a, input int b, input int op, output int waits);
      cmd_valid = 1'b1;
      cmd_load  = (ld != 0);
      cmd_we    = (we != 0);
      cmd_data  = W'(data);
      cmd_dst   = AW'(dst);
      cmd_a     = AW'(a);
      cmd_b     = AW'(b);
      cmd_op    = 4'(op);
      waits     = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         waits++;
         if (waits > 200) begin
            chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic doReset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_data", {24'd0, res_data}, 32'd0);
      chk("rst_res_dst", {28'd0, res_dst}, 32'd0);
      chk("rst_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
      for (int i = 0; i < N; i++) begin
         dbg_sel = AW'(i);
         #0.1;
         chk("rst_reg_zero", {24'd0, dbg_data}, 32'd0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      expQ.delete();
      foreach (mregs[i]) mregs[i] = 0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic expectLast(input string tag, input int data, input int zcn);
      idle(4);
      chk({tag, "_data"}, {24'd0, res_data}, data);
      chk({tag, "_zcn"}, {29'd0, flag_z, flag_c, flag_n}, zcn);
   endtask

   task automatic expectReg(input string tag, input int r, input int val);
      dbg_sel = AW'(r);
      #1;
      chk(tag, {24'd0, dbg_data}, val);
   endtask

   initial begin
      int w, w2;
      reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_we = 1'b0;
      cmd_data = '0; cmd_dst = '0; cmd_a = '0; cmd_b = '0; cmd_op = '0; dbg_sel = '0;
      doReset();

      // LOAD/LOAD/ADD crossing into the sign bit
      send(1, 1, 'h7F, 3, 0, 0, 0, w);
      send(1, 1, 'h01, 4, 0, 0, 0, w);
      send(0, 1, 0, 5, 3, 4, 0, w);
      expectLast("add", 'h80, 3'b001);
      expectReg("dbg_r5", 5, 'h80);

      // back-to-back dependency through the bypass
      send(1, 1, 'h05, 1, 0, 0, 0, w);
      chk("b2b_ready_first", w, 0);
      send(0, 1, 0, 2, 1, 1, 0, w);
      chk("b2b_ready_second", w, 0);
      expectLast("b2b_add", 'h0A, 3'b000);
      expectReg("dbg_r2", 2, 'h0A);

      send(1, 1, 'h03, 8, 0, 0, 0, w);
      send(1, 1, 'h05, 9, 0, 0, 0, w);
      send(0, 1, 0, 10, 8, 9, 1, w);
      expectLast("sub_borrow", 'hFE, 3'b011);

      send(1, 1, 'h5A, 6, 0, 0, 0, w);
      send(0, 0, 0, 6, 6, 6, 1, w);
      expectLast("sub_compare", 'h00, 3'b100);
      expectReg("r6_kept", 6, 'h5A);

      send(1, 1, 'h81, 11, 0, 0, 0, w);
      send(0, 1, 0, 12, 11, 0, 6, w);
      expectLast("shl", 'h02, 3'b010);
      send(1, 1, 'h01, 13, 0, 0, 0, w);
      send(0, 1, 0, 14, 13, 0, 7, w);
      expectLast("shr", 'h00, 3'b110);

`ifdef PARAM_DATAPATH_MUL_EN
      send(1, 1, 'h0C, 1, 0, 0, 0, w);
      send(1, 1, 'h0B, 2, 0, 0, 0, w);
      send(0, 1, 0, 7, 1, 2, 9, w);
      send(0, 1, 0, 8, 7, 7, 0, w);
      chk("mul_follower_accepted", w, 0);
      send(0, 1, 0, 9, 8, 0, 8, w2);
      chk("mul_ready_low_cycles", w2, 8);
      idle(6);
      expectReg("dbg_r7_mul", 7, 'h84);
      expectReg("dbg_r8_fwd", 8, 'h08);
      expectReg("dbg_r9_fwd", 9, 'h08);

      send(1, 1, 'h10, 1, 0, 0, 0, w);
      send(0, 1, 0, 3, 1, 1, 9, w);
      idle(12);
      chk("mul_ovf_data", {24'd0, res_data}, 32'h0);
      chk("mul_ovf_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b110);

      send(1, 1, 'h33, 1, 0, 0, 0, w);
      send(0, 1, 0, 4, 1, 1, 9, w);
      idle(3);
      doReset();
      idle(12);
      expectReg("mul_abort_r4", 4, 0);
`endif

      for (int i = 0; i < 400; i++) begin
         send(($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0,
              $urandom_range(0, M), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
              $urandom_range(0, N - 1), $urandom_range(0, 15), w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(30);
      chk("drain_pending", expQ.size(), 0);
      for (int i = 0; i < N; i++) expectReg("final_reg", i, mregs[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
